// File: rtl/board_supervisor_if.sv
// Control and status bundle between the board supervisor and its environment.
// The master side drives the strobes and requests; the slave side is the supervisor.
interface board_supervisor_if #(
  parameter int TS_WIDTH = 24
);
  logic                tick;
  logic                start_req;
  logic                stop_req;
  logic                arm_req;
  logic                radio_ok;
  logic [1:0]          state;
  logic                sub_rst;
  logic                motor_en;
  logic                fault;
  logic [TS_WIDTH-1:0] timestamp;

  modport master (
    output tick, start_req, stop_req, arm_req, radio_ok,
    input  state, sub_rst, motor_en, fault, timestamp
  );

  modport slave (
    input  tick, start_req, stop_req, arm_req, radio_ok,
    output state, sub_rst, motor_en, fault, timestamp
  );
endinterface

// File: rtl/board_supervisor.sv
// Board power-state supervisor: start/stop sequencing, motor arm qualification,
// radio-loss watchdog with sticky fault, and a RUNNING-time tick counter.
module board_supervisor #(
  parameter int TS_WIDTH       = 24,
  parameter int STARTUP_TICKS  = 16,
  parameter int SHUTDOWN_TICKS = 8,
  parameter int ARM_HOLD       = 5,
  parameter int WDOG_TICKS     = 10
) (
  input logic               clk,
  input logic               rst_n,
  board_supervisor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STARTUP  = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_SHUTDOWN = 2'd3
  } state_e;

  localparam int PH_MAX = (STARTUP_TICKS > SHUTDOWN_TICKS) ? STARTUP_TICKS : SHUTDOWN_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int ARM_W  = $clog2(ARM_HOLD + 1);
  localparam int WD_W   = $clog2(WDOG_TICKS + 1);

  localparam logic [PH_W-1:0]     PH_ZERO       = PH_W'(1'b0);
  localparam logic [PH_W-1:0]     PH_ONE        = PH_W'(1'b1);
  localparam logic [PH_W-1:0]     STARTUP_LAST  = PH_W'(STARTUP_TICKS - 1);
  localparam logic [PH_W-1:0]     SHUTDOWN_LAST = PH_W'(SHUTDOWN_TICKS - 1);
  localparam logic [ARM_W-1:0]    ARM_ZERO      = ARM_W'(1'b0);
  localparam logic [ARM_W-1:0]    ARM_ONE       = ARM_W'(1'b1);
  localparam logic [ARM_W-1:0]    ARM_FULL      = ARM_W'(ARM_HOLD);
  localparam logic [WD_W-1:0]     WD_ZERO       = WD_W'(1'b0);
  localparam logic [WD_W-1:0]     WD_ONE        = WD_W'(1'b1);
  localparam logic [WD_W-1:0]     WD_LAST       = WD_W'(WDOG_TICKS - 1);
  localparam logic [TS_WIDTH-1:0] TS_ZERO       = TS_WIDTH'(1'b0);
  localparam logic [TS_WIDTH-1:0] TS_ONE        = TS_WIDTH'(1'b1);

  state_e              state_r, state_next_s;
  logic [PH_W-1:0]     phase_r, phase_next_s;
  logic [TS_WIDTH-1:0] ts_r, ts_next_s;
  logic [ARM_W-1:0]    arm_cnt_r, arm_cnt_next_s;
  logic [WD_W-1:0]     wdog_r, wdog_next_s;
  logic                arm_used_r, arm_used_next_s;
  logic                fault_r, fault_next_s;
  logic                motor_en_r, motor_en_next_s;
  logic                sub_rst_r, sub_rst_next_s;
  logic                start_q_r, stop_q_r;
  logic                start_edge_s, stop_edge_s;
  logic                arm_toggle_s, wdog_trip_s;

  assign start_edge_s = bus.start_req & ~start_q_r;
  assign stop_edge_s  = bus.stop_req & ~stop_q_r;

  // Next-state, counter and output computation for the supervisor.
  always_comb begin
    state_next_s    = state_r;
    phase_next_s    = phase_r;
    ts_next_s       = ts_r;
    fault_next_s    = fault_r;
    arm_cnt_next_s  = arm_cnt_r;
    arm_used_next_s = arm_used_r;
    wdog_next_s     = wdog_r;
    arm_toggle_s    = 1'b0;
    wdog_trip_s     = 1'b0;

    // A full qualifier is consumed even outside RUNNING, so a switch already held
    // at RUNNING entry must be released and pressed again before it arms.
    if ((arm_cnt_r == ARM_FULL) && !arm_used_r) begin
      arm_toggle_s    = (state_r == ST_RUNNING);
      arm_used_next_s = 1'b1;
    end else begin
      arm_toggle_s    = 1'b0;
    end

    if (bus.tick) begin
      if (bus.arm_req) begin
        if (arm_cnt_r != ARM_FULL) begin
          arm_cnt_next_s = arm_cnt_r + ARM_ONE;
        end else begin
          arm_cnt_next_s = arm_cnt_r;
        end
      end else begin
        arm_cnt_next_s  = ARM_ZERO;
        arm_used_next_s = 1'b0;
      end
    end else begin
      arm_cnt_next_s = arm_cnt_r;
    end

    if (state_r != ST_RUNNING) begin
      wdog_next_s = WD_ZERO;
    end else if (bus.tick) begin
      if (!bus.radio_ok) begin
        wdog_next_s = wdog_r + WD_ONE;
        wdog_trip_s = (wdog_r == WD_LAST);
      end else begin
        wdog_next_s = WD_ZERO;
      end
    end else begin
      wdog_next_s = wdog_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_next_s = ST_STARTUP;
          phase_next_s = PH_ZERO;
          ts_next_s    = TS_ZERO;
          fault_next_s = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STARTUP: begin
        if (stop_edge_s) begin
          state_next_s = ST_SHUTDOWN;
          phase_next_s = PH_ZERO;
        end else if (bus.tick) begin
          if (phase_r == STARTUP_LAST) begin
            state_next_s = ST_RUNNING;
            phase_next_s = PH_ZERO;
          end else begin
            phase_next_s = phase_r + PH_ONE;
          end
        end else begin
          state_next_s = ST_STARTUP;
        end
      end
      ST_RUNNING: begin
        if (bus.tick) begin
          ts_next_s = ts_r + TS_ONE;
        end else begin
          ts_next_s = ts_r;
        end
        if (stop_edge_s || wdog_trip_s) begin
          state_next_s = ST_SHUTDOWN;
          phase_next_s = PH_ZERO;
          fault_next_s = fault_r | wdog_trip_s;
        end else begin
          state_next_s = ST_RUNNING;
        end
      end
      ST_SHUTDOWN: begin
        if (bus.tick) begin
          if (phase_r == SHUTDOWN_LAST) begin
            state_next_s = ST_IDLE;
            phase_next_s = PH_ZERO;
          end else begin
            phase_next_s = phase_r + PH_ONE;
          end
        end else begin
          state_next_s = ST_SHUTDOWN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        phase_next_s = PH_ZERO;
      end
    endcase

    // Outputs follow the next state so they line up with the state register.
    if (state_next_s == ST_RUNNING) begin
      motor_en_next_s = motor_en_r ^ arm_toggle_s;
    end else begin
      motor_en_next_s = 1'b0;
    end
    sub_rst_next_s = (state_next_s == ST_IDLE);
  end

  // State, counters, edge samples and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      phase_r    <= PH_ZERO;
      ts_r       <= TS_ZERO;
      arm_cnt_r  <= ARM_ZERO;
      arm_used_r <= 1'b0;
      wdog_r     <= WD_ZERO;
      fault_r    <= 1'b0;
      motor_en_r <= 1'b0;
      sub_rst_r  <= 1'b1;
      start_q_r  <= 1'b0;
      stop_q_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      phase_r    <= phase_next_s;
      ts_r       <= ts_next_s;
      arm_cnt_r  <= arm_cnt_next_s;
      arm_used_r <= arm_used_next_s;
      wdog_r     <= wdog_next_s;
      fault_r    <= fault_next_s;
      motor_en_r <= motor_en_next_s;
      sub_rst_r  <= sub_rst_next_s;
      start_q_r  <= bus.start_req;
      stop_q_r   <= bus.stop_req;
    end
  end

  assign bus.state     = state_r;
  assign bus.sub_rst   = sub_rst_r;
  assign bus.motor_en  = motor_en_r;
  assign bus.fault     = fault_r;
  assign bus.timestamp = ts_r;

endmodule

// File: tb/tb_board_supervisor.sv
// Directed bench for board_supervisor with small parameters so every sequence
// (startup, arming, watchdog, timestamp wrap, reset) fits in a few ticks.
module tb_board_supervisor;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_failed;

  board_supervisor_if #(.TS_WIDTH(4)) bus ();

  board_supervisor #(
    .TS_WIDTH(4),
    .STARTUP_TICKS(4),
    .SHUTDOWN_TICKS(2),
    .ARM_HOLD(3),
    .WDOG_TICKS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One tick strobe followed by one quiet clk for registered follow-ups.
  task automatic tick_once();
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_failed      = 0;
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.start_req = 1'b0;
    bus.stop_req  = 1'b0;
    bus.arm_req   = 1'b0;
    bus.radio_ok  = 1'b1;
    cycle();
    cycle();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_sub_rst", 32'(bus.sub_rst), 32'd1);
    check("rst_motor", 32'(bus.motor_en), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_ts", 32'(bus.timestamp), 32'd0);
    rst_n = 1'b1;
    cycle();
    cycle();
    check("post_rst_idle", 32'(bus.state), 32'd0);

    // Startup sequence
    bus.start_req = 1'b1;
    cycle();
    bus.start_req = 1'b0;
    check("start_state", 32'(bus.state), 32'd1);
    check("start_sub_rst", 32'(bus.sub_rst), 32'd0);
    ticks(3);
    check("startup_3ticks", 32'(bus.state), 32'd1);
    ticks(1);
    check("startup_done", 32'(bus.state), 32'd2);
    check("run_ts0", 32'(bus.timestamp), 32'd0);

    // Arm qualification
    bus.arm_req = 1'b1;
    ticks(2);
    check("arm_2ticks", 32'(bus.motor_en), 32'd0);
    ticks(1);
    check("arm_3ticks", 32'(bus.motor_en), 32'd1);
    check("ts_3", 32'(bus.timestamp), 32'd3);
    ticks(10);
    check("arm_held", 32'(bus.motor_en), 32'd1);
    bus.arm_req = 1'b0;
    ticks(1);
    check("arm_released", 32'(bus.motor_en), 32'd1);
    bus.arm_req = 1'b1;
    ticks(3);
    check("arm_toggle_off", 32'(bus.motor_en), 32'd0);
    check("ts_wrap_17", 32'(bus.timestamp), 32'd1);
    bus.arm_req = 1'b0;
    ticks(1);
    bus.arm_req = 1'b1;
    ticks(3);
    check("rearm_on", 32'(bus.motor_en), 32'd1);
    check("ts_5", 32'(bus.timestamp), 32'd5);

    // Radio-loss watchdog
    bus.radio_ok = 1'b0;
    ticks(1);
    check("wdog_1tick_fault", 32'(bus.fault), 32'd0);
    check("wdog_1tick_motor", 32'(bus.motor_en), 32'd1);
    ticks(1);
    check("wdog_fault", 32'(bus.fault), 32'd1);
    check("wdog_motor", 32'(bus.motor_en), 32'd0);
    check("wdog_state", 32'(bus.state), 32'd3);
    check("wdog_ts", 32'(bus.timestamp), 32'd7);
    bus.radio_ok = 1'b1;
    bus.arm_req  = 1'b0;
    ticks(1);
    check("shutdown_1tick", 32'(bus.state), 32'd3);
    ticks(1);
    check("shutdown_idle", 32'(bus.state), 32'd0);
    check("idle_sub_rst", 32'(bus.sub_rst), 32'd1);
    check("fault_sticky", 32'(bus.fault), 32'd1);
    check("idle_ts_hold", 32'(bus.timestamp), 32'd7);

    // Timestamp wrap and stop request
    bus.start_req = 1'b1;
    cycle();
    bus.start_req = 1'b0;
    check("restart_fault_clr", 32'(bus.fault), 32'd0);
    check("restart_ts_clr", 32'(bus.timestamp), 32'd0);
    ticks(4);
    ticks(17);
    check("run17_state", 32'(bus.state), 32'd2);
    check("run17_ts", 32'(bus.timestamp), 32'd1);
    bus.stop_req = 1'b1;
    cycle();
    bus.stop_req = 1'b0;
    check("stop_state", 32'(bus.state), 32'd3);
    check("stop_ts_hold", 32'(bus.timestamp), 32'd1);
    bus.start_req = 1'b1;
    cycle();
    bus.start_req = 1'b0;
    check("start_in_shutdown", 32'(bus.state), 32'd3);
    ticks(2);
    check("stop_to_idle", 32'(bus.state), 32'd0);
    cycle();
    check("start_not_queued", 32'(bus.state), 32'd0);
    check("idle_ts_1", 32'(bus.timestamp), 32'd1);

    // Stop during STARTUP with arm held
    bus.start_req = 1'b1;
    cycle();
    bus.start_req = 1'b0;
    bus.arm_req   = 1'b1;
    ticks(2);
    check("startup_2ticks", 32'(bus.state), 32'd1);
    bus.stop_req = 1'b1;
    cycle();
    bus.stop_req = 1'b0;
    check("startup_stop", 32'(bus.state), 32'd3);
    check("startup_stop_motor", 32'(bus.motor_en), 32'd0);
    ticks(2);
    check("startup_stop_idle", 32'(bus.state), 32'd0);
    check("startup_stop_motor_idle", 32'(bus.motor_en), 32'd0);
    bus.arm_req = 1'b0;
    ticks(1);

    // Stop edge and watchdog trip in the same clk
    bus.start_req = 1'b1;
    cycle();
    bus.start_req = 1'b0;
    ticks(4);
    bus.arm_req = 1'b1;
    ticks(3);
    check("sim_motor_on", 32'(bus.motor_en), 32'd1);
    bus.radio_ok = 1'b0;
    ticks(1);
    check("sim_pre_fault", 32'(bus.fault), 32'd0);
    bus.tick     = 1'b1;
    bus.stop_req = 1'b1;
    cycle();
    bus.tick     = 1'b0;
    bus.stop_req = 1'b0;
    check("sim_state", 32'(bus.state), 32'd3);
    check("sim_fault", 32'(bus.fault), 32'd1);
    check("sim_motor", 32'(bus.motor_en), 32'd0);
    bus.radio_ok = 1'b1;
    bus.arm_req  = 1'b0;
    cycle();
    ticks(2);
    check("sim_idle", 32'(bus.state), 32'd0);

    // Tick coincident with start edge is not counted
    bus.start_req = 1'b1;
    bus.tick      = 1'b1;
    cycle();
    bus.start_req = 1'b0;
    bus.tick      = 1'b0;
    cycle();
    check("coinc_state", 32'(bus.state), 32'd1);
    check("coinc_fault_clr", 32'(bus.fault), 32'd0);
    ticks(3);
    check("coinc_3ticks", 32'(bus.state), 32'd1);
    ticks(1);
    check("coinc_running", 32'(bus.state), 32'd2);

    // Asynchronous reset while running and armed
    bus.arm_req = 1'b1;
    ticks(3);
    check("pre_rst_motor", 32'(bus.motor_en), 32'd1);
    check("pre_rst_ts", 32'(bus.timestamp), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.state), 32'd0);
    check("async_rst_motor", 32'(bus.motor_en), 32'd0);
    check("async_rst_ts", 32'(bus.timestamp), 32'd0);
    check("async_rst_sub_rst", 32'(bus.sub_rst), 32'd1);
    cycle();
    rst_n       = 1'b1;
    bus.arm_req = 1'b0;
    cycle();
    ticks(2);
    check("post_rst2_idle", 32'(bus.state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
